// File: rtl/muldiv_pkg.sv
// muldiv_pkg: shared op and state encodings for the multiply/divide unit.
package muldiv_pkg;

    typedef enum logic [2:0] {
        MD_MULT  = 3'b000,
        MD_MULTU = 3'b001,
        MD_DIV   = 3'b010,
        MD_DIVU  = 3'b011,
        MD_MTHI  = 3'b100,
        MD_MTLO  = 3'b101
    } md_op_e;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } md_state_e;

endpackage

// File: rtl/muldiv_step.sv
// muldiv_step: one shift-add multiply step or one restoring-divide step.
// Multiply acc = {partial product, remaining multiplier}; divide acc = {remainder, dividend/quotient}.
module muldiv_step #(
    parameter int WIDTH = 32
) (
    input  logic [2*WIDTH-1:0] acc_i,
    input  logic [WIDTH-1:0]   opnd_i,
    input  logic               div_i,
    output logic [2*WIDTH-1:0] acc_o
);

    logic [WIDTH:0] sum, tmp, diff;

    always_comb begin
        sum   = {1'b0, acc_i[2*WIDTH-1:WIDTH]} + {1'b0, opnd_i};
        tmp   = acc_i[2*WIDTH-1:WIDTH-1];
        diff  = tmp - {1'b0, opnd_i};
        // diff[WIDTH] is the borrow: remainder smaller than divisor, restore
        acc_o = div_i ? (diff[WIDTH] ? {tmp[WIDTH-1:0], acc_i[WIDTH-2:0], 1'b0}
                                     : {diff[WIDTH-1:0], acc_i[WIDTH-2:0], 1'b1})
                      : (acc_i[0] ? {sum, acc_i[WIDTH-1:1]} : {1'b0, acc_i[2*WIDTH-1:1]});
    end

endmodule

// File: rtl/muldiv_unit.sv
// muldiv_unit: iterative MULT/MULTU/DIV/DIVU with HI/LO registers and MTHI/MTLO.
// Operates on magnitudes; signs are reapplied on the final CALC edge.
module muldiv_unit
    import muldiv_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    output logic             busy,
    output logic             done,
    output logic             div_by_zero,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    localparam int CW = $clog2(WIDTH + 1);

    md_state_e          state_q, state_d;
    logic [CW-1:0]      cnt_q, cnt_d;
    logic [WIDTH-1:0]   opnd_q, opnd_d, hi_q, hi_d, lo_q, lo_d;
    logic [2*WIDTH-1:0] acc_q, acc_d, acc_nx, prod;
    logic               neg_q, neg_d, rneg_q, rneg_d, dz_q, dz_d, div_q, div_d;
    logic               sgn;
    logic [WIDTH-1:0]   a_abs, b_abs, quo, rem;

    muldiv_step #(.WIDTH(WIDTH)) u_step (
        .acc_i  (acc_q),
        .opnd_i (opnd_q),
        .div_i  (div_q),
        .acc_o  (acc_nx)
    );

    always_comb begin
        sgn     = ~op[0];
        a_abs   = (sgn && A[WIDTH-1]) ? -A : A;
        b_abs   = (sgn && B[WIDTH-1]) ? -B : B;
        prod    = neg_q ? -acc_nx : acc_nx;
        quo     = dz_q ? '1 : (neg_q ? -acc_nx[WIDTH-1:0] : acc_nx[WIDTH-1:0]);
        // a zero divisor leaves |A| as remainder, so the sign fix restores A itself
        rem     = rneg_q ? -acc_nx[2*WIDTH-1:WIDTH] : acc_nx[2*WIDTH-1:WIDTH];
        state_d = state_q;
        cnt_d   = cnt_q;
        opnd_d  = opnd_q;
        acc_d   = acc_q;
        neg_d   = neg_q;
        rneg_d  = rneg_q;
        dz_d    = dz_q;
        div_d   = div_q;
        hi_d    = hi_q;
        lo_d    = lo_q;
        if (state_q == IDLE && start) begin
            if (!op[2]) begin
                state_d = CALC;
                cnt_d   = '0;
                div_d   = op[1];
                opnd_d  = op[1] ? b_abs : a_abs;
                acc_d   = {{WIDTH{1'b0}}, op[1] ? a_abs : b_abs};
                neg_d   = sgn & (A[WIDTH-1] ^ B[WIDTH-1]);
                rneg_d  = sgn & A[WIDTH-1];
                dz_d    = op[1] & (B == '0);
            end else if (op == MD_MTHI) begin
                hi_d = A;
            end else if (op == MD_MTLO) begin
                lo_d = A;
            end
        end else if (state_q == CALC) begin
            acc_d = acc_nx;
            cnt_d = cnt_q + 1'b1;
            if (cnt_q == CW'(WIDTH - 1)) begin
                state_d = DONE;
                hi_d    = div_q ? rem : prod[2*WIDTH-1:WIDTH];
                lo_d    = div_q ? quo : prod[WIDTH-1:0];
            end
        end else if (state_q == DONE) begin
            state_d = IDLE;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            opnd_q  <= '0;
            acc_q   <= '0;
            neg_q   <= 1'b0;
            rneg_q  <= 1'b0;
            dz_q    <= 1'b0;
            div_q   <= 1'b0;
            hi_q    <= '0;
            lo_q    <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            opnd_q  <= opnd_d;
            acc_q   <= acc_d;
            neg_q   <= neg_d;
            rneg_q  <= rneg_d;
            dz_q    <= dz_d;
            div_q   <= div_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
        end
    end

    assign busy        = (state_q == CALC);
    assign done        = (state_q == DONE);
    assign div_by_zero = done & dz_q;
    assign hi          = hi_q;
    assign lo          = lo_q;

endmodule

// File: tb/tb_muldiv_unit.sv
// tb_muldiv_unit: directed tests for muldiv_unit with hand-computed HI/LO results.
module tb_muldiv_unit;
    import muldiv_pkg::*;

    logic        clk = 1'b0, rst = 1'b1, start = 1'b0;
    logic [2:0]  op = 3'b0;
    logic [31:0] A = '0, B = '0;
    logic        busy, done, div_by_zero;
    logic [31:0] hi, lo;
    int          total = 0, bad = 0;

    muldiv_unit #(.WIDTH(32)) dut (
        .clk(clk), .rst(rst), .start(start), .op(op), .A(A), .B(B),
        .busy(busy), .done(done), .div_by_zero(div_by_zero), .hi(hi), .lo(lo)
    );

    always #5 clk = ~clk;

    task automatic do_op(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b,
                         output int lat, output int early);
        @(negedge clk);
        op = o; A = a; B = b; start = 1'b1;
        @(negedge clk);
        start = 1'b0; lat = 0; early = 0;
        while (busy && lat < 100) begin
            lat++;
            if (done || div_by_zero) early++;
            @(negedge clk);
        end
    endtask

    task automatic test_reset;
        repeat (2) @(negedge clk);
        total++; if ({busy, done, div_by_zero} !== 3'b000) begin bad++; $display("FAIL reset_flags got=%b exp=000", {busy, done, div_by_zero}); end
        total++; if ({hi, lo} !== 64'h0) begin bad++; $display("FAIL reset_hilo got=%h exp=0", {hi, lo}); end
        rst = 1'b0;
    endtask

    task automatic test_mul;
        int lat, early;
        do_op(MD_MULT, 32'hFFFF_FFFF, 32'd3, lat, early);
        total++; if (lat !== 32) begin bad++; $display("FAIL mult_latency got=%0d exp=32", lat); end
        total++; if (done !== 1'b1) begin bad++; $display("FAIL mult_done got=%b exp=1", done); end
        total++; if ({hi, lo} !== 64'hFFFF_FFFF_FFFF_FFFD) begin bad++; $display("FAIL mult_result got=%h exp=ffffffff_fffffffd", {hi, lo}); end
        @(negedge clk);
        total++; if (done !== 1'b0) begin bad++; $display("FAIL mult_done_pulse got=%b exp=0", done); end
        do_op(MD_MULTU, 32'hFFFF_FFFF, 32'd3, lat, early);
        total++; if ({hi, lo} !== 64'h0000_0002_FFFF_FFFD) begin bad++; $display("FAIL multu_result got=%h exp=00000002_fffffffd", {hi, lo}); end
        do_op(MD_MULT, 32'hFFFF_FFFB, 32'hFFFF_FFFA, lat, early);
        total++; if ({hi, lo} !== 64'h0000_0000_0000_001E) begin bad++; $display("FAIL mult_negneg got=%h exp=1e", {hi, lo}); end
        total++; if (early !== 0) begin bad++; $display("FAIL mult_early_done got=%0d exp=0", early); end
    endtask

    task automatic test_div;
        int lat, early;
        do_op(MD_DIV, 32'hFFFF_FFF9, 32'd2, lat, early);
        total++; if (lat !== 32) begin bad++; $display("FAIL div_latency got=%0d exp=32", lat); end
        total++; if ({hi, lo} !== 64'hFFFF_FFFF_FFFF_FFFD) begin bad++; $display("FAIL div_neg got=%h exp=ffffffff_fffffffd", {hi, lo}); end
        do_op(MD_DIVU, 32'd7, 32'd2, lat, early);
        total++; if ({hi, lo} !== 64'h0000_0001_0000_0003) begin bad++; $display("FAIL divu got=%h exp=00000001_00000003", {hi, lo}); end
        do_op(MD_DIV, 32'd7, 32'hFFFF_FFFE, lat, early);
        total++; if ({hi, lo} !== 64'h0000_0001_FFFF_FFFD) begin bad++; $display("FAIL div_negdivisor got=%h exp=00000001_fffffffd", {hi, lo}); end
        do_op(MD_DIV, 32'h8000_0000, 32'hFFFF_FFFF, lat, early);
        total++; if ({hi, lo} !== 64'h0000_0000_8000_0000) begin bad++; $display("FAIL div_overflow got=%h exp=00000000_80000000", {hi, lo}); end
        total++; if (div_by_zero !== 1'b0) begin bad++; $display("FAIL div_overflow_flag got=%b exp=0", div_by_zero); end
    endtask

    task automatic test_div_zero;
        int lat, early;
        do_op(MD_DIVU, 32'd7, 32'd0, lat, early);
        total++; if (lat !== 32) begin bad++; $display("FAIL dz_latency got=%0d exp=32", lat); end
        total++; if (early !== 0) begin bad++; $display("FAIL dz_flag_early got=%0d exp=0", early); end
        total++; if ({done, div_by_zero} !== 2'b11) begin bad++; $display("FAIL dz_flag got=%b exp=11", {done, div_by_zero}); end
        total++; if ({hi, lo} !== 64'h0000_0007_FFFF_FFFF) begin bad++; $display("FAIL dz_result got=%h exp=00000007_ffffffff", {hi, lo}); end
        @(negedge clk);
        total++; if (div_by_zero !== 1'b0) begin bad++; $display("FAIL dz_flag_after got=%b exp=0", div_by_zero); end
    endtask

    task automatic test_mt;
        int flags = 0;
        @(negedge clk);
        op = MD_MTHI; A = 32'h1234; start = 1'b1;
        @(negedge clk);
        flags += int'(busy) + int'(done);
        total++; if (hi !== 32'h1234) begin bad++; $display("FAIL mthi got=%h exp=00001234", hi); end
        op = MD_MTLO; A = 32'h5678;
        @(negedge clk);
        flags += int'(busy) + int'(done);
        op = 3'b110; A = 32'hDEAD_BEEF;
        @(negedge clk);
        flags += int'(busy) + int'(done);
        start = 1'b0;
        @(negedge clk);
        flags += int'(busy) + int'(done);
        total++; if ({hi, lo} !== 64'h0000_1234_0000_5678) begin bad++; $display("FAIL mt_result got=%h exp=00001234_00005678", {hi, lo}); end
        total++; if (flags !== 0) begin bad++; $display("FAIL mt_busy_done got=%0d exp=0", flags); end
    endtask

    task automatic test_back_to_back;
        int lat = 0;
        @(negedge clk);
        op = MD_MULTU; A = 32'h0001_0000; B = 32'h0001_0000; start = 1'b1;
        @(negedge clk);
        A = 32'd3; B = 32'd3;
        while (busy && lat < 100) begin
            lat++;
            start = ~start;
            @(negedge clk);
        end
        total++; if (lat !== 32) begin bad++; $display("FAIL b2b_latency got=%0d exp=32", lat); end
        total++; if ({hi, lo} !== 64'h0000_0001_0000_0000) begin bad++; $display("FAIL b2b_result got=%h exp=00000001_00000000", {hi, lo}); end
        op = MD_MTHI; A = 32'hAAAA; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        total++; if ({busy, hi} !== {1'b0, 32'h1}) begin bad++; $display("FAIL start_in_done got=%h exp=000000001", {busy, hi}); end
    endtask

    task automatic test_reset_mid;
        int lat, early;
        @(negedge clk);
        op = MD_DIV; A = 32'd100; B = 32'd0; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (9) @(negedge clk);
        total++; if (busy !== 1'b1) begin bad++; $display("FAIL rmid_busy got=%b exp=1", busy); end
        #1 rst = 1'b1;
        #1;
        total++; if ({busy, done, div_by_zero} !== 3'b000) begin bad++; $display("FAIL rmid_flags got=%b exp=000", {busy, done, div_by_zero}); end
        total++; if ({hi, lo} !== 64'h0) begin bad++; $display("FAIL rmid_hilo got=%h exp=0", {hi, lo}); end
        @(negedge clk);
        rst = 1'b0;
        do_op(MD_DIVU, 32'd100, 32'd7, lat, early);
        total++; if (lat !== 32) begin bad++; $display("FAIL rmid_latency got=%0d exp=32", lat); end
        total++; if ({hi, lo} !== 64'h0000_0002_0000_000E) begin bad++; $display("FAIL rmid_divu got=%h exp=00000002_0000000e", {hi, lo}); end
    endtask

    initial begin
        test_reset();
        test_mul();
        test_div();
        test_div_zero();
        test_back_to_back();
        test_mt();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/muldiv_unit.md
# muldiv_unit

Parametrised iterative multiply/divide unit with HI/LO result registers for the multicycle MIPS datapath. It executes MULT/MULTU/DIV/DIVU over WIDTH cycles and MTHI/MTLO in a single cycle. A start/busy/done handshake lets the control FSM stall while the operation runs. It sits beside the combinational ALU: both read the same A/B operand buses, and HI/LO feed the MFHI/MFLO write-back mux.

## Interface
Parameters:
- WIDTH, 32: operand width and HI/LO width; must be even and ≥ 4.

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  asynchronous, active-high reset.
- start  in  1  request; sampled only in IDLE.
- op  in  3  000 MULT, 001 MULTU, 010 DIV, 011 DIVU, 100 MTHI, 101 MTLO; 110/111 are ignored (no state change).
- A  in  WIDTH  multiplicand / dividend / MTHI–MTLO source.
- B  in  WIDTH  multiplier / divisor.
- busy  out  1  high while an iterative operation is running.
- done  out  1  one-cycle pulse; HI/LO hold the new result during it.
- div_by_zero  out  1  high with done when a DIV/DIVU had B == 0.
- hi  out  WIDTH  HI register.
- lo  out  WIDTH  LO register.

## Operation
- States:
  - IDLE → CALC on start with op in 000..011.
  - CALC → DONE after WIDTH steps.
  - DONE → IDLE unconditionally.
- busy = (state == CALC); done = (state == DONE). Both are decoded from registered state.
- On acceptance, latch:
  - |A| and |B| for signed ops, raw values for unsigned ops;
  - result sign flags: product sign = A[W-1]^B[W-1]; quotient sign = the same; remainder sign = A[W-1];
  - a zero-divisor flag;
  - step counter = 0.
- Multiply: radix-2 shift-add, one partial-product bit per cycle, into a 2·WIDTH accumulator.
- Divide: restoring division, one quotient bit per cycle.
- On the last CALC edge, negate any result whose sign flag is set, then write HI/LO:
  - mul: HI = product[2W-1:W], LO = product[W-1:0];
  - div: LO = quotient, HI = remainder.
- Divide by zero: full WIDTH latency; result is LO = all ones, HI = A (as latched); div_by_zero = 1 during DONE.
- Signed overflow: DIV of MIN_INT by −1 gives LO = MIN_INT (wraps), HI = 0, and no flag.
- MTHI/MTLO: when start is seen in IDLE, HI (or LO) = A on that edge. There is no busy and no done.
- start in CALC or DONE is ignored; operands are not resampled.
- HI/LO change only on a completed operation, on MTHI/MTLO, or on reset. Intermediate values are never visible on hi/lo.

## Timing
- Reset (asynchronous, any state, including mid-CALC): state = IDLE, busy = 0, done = 0, div_by_zero = 0, hi = 0, lo = 0. The interrupted operation is discarded.
- Let E0 be the edge that accepts start:
  - busy is high in cycles E0..E_WIDTH (exactly WIDTH cycles).
  - HI/LO update on E_WIDTH.
  - done is high for the single cycle after E_WIDTH.
  - Earliest next accept is E_(WIDTH+2).
- MTHI/MTLO: value is visible on hi/lo in the cycle after the accepting edge.
- All arithmetic is modulo 2^WIDTH (2^(2·WIDTH) for the product accumulator). The step counter is $clog2(WIDTH+1) bits.

## Structure
- Shared package (muldiv_pkg):
  - op encodings MD_MULT..MD_MTLO;
  - state encoding IDLE/CALC/DONE.
- Add the op codes alongside the existing ALUOp constant definitions so the control FSM uses one include.
- Sub-module muldiv_step (combinational): given accumulator/remainder state, operand and mode, produces the next iteration value. The top level holds the FSM, counter, sign handling and HI/LO registers.

## Test plan
- MULT A=0xFFFFFFFF, B=3 → after 32 busy cycles, done: hi=0xFFFFFFFF, lo=0xFFFFFFFD. MULTU with the same operands → hi=0x00000002, lo=0xFFFFFFFD.
- DIV A=−7 (0xFFFFFFF9), B=2 → lo=0xFFFFFFFD, hi=0xFFFFFFFF. DIVU A=7, B=2 → lo=3, hi=1.
- DIVU A=7, B=0 → lo=0xFFFFFFFF, hi=7, div_by_zero=1 only during done. DIV A=0x80000000, B=0xFFFFFFFF → lo=0x80000000, hi=0, no flag.
- MTHI A=0x1234 then MTLO A=0x5678 on consecutive cycles → hi=0x1234, lo=0x5678, busy and done never asserted.
- Start a MULT; toggle start with different operands during busy → result matches the first operands only; latency is exactly 32 cycles.
- Assert rst at cycle 10 of a DIV → busy, done and div_by_zero drop immediately, hi=lo=0. A new DIVU then completes correctly.
